// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage rv32i core: freezes on memory waits, inserts load-use
// bubbles, flushes on EX redirects, buffers one fetched instruction and counts stall cycles.
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src1,
  input  logic             id_uses_src2,
  input  logic [4:0]       ex_dest,
  input  logic             ex_dmem_read,
  input  logic             ex_redirect,
  output logic             imem_read,
  output logic [31:0]      if_instr,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic [CNT_W-1:0] stall_cycles
);

  logic             hold_valid_q, hold_valid_d;
  logic [31:0]      hold_instr_q, hold_instr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic fetch_ok, istall, dstall, freeze;
  logic src1_hit, src2_hit, lu_hazard;

  assign fetch_ok  = hold_valid_q | imem_resp;
  assign istall    = ~fetch_ok;
  assign dstall    = dmem_req & ~dmem_resp;
  assign freeze    = istall | dstall;
  assign src1_hit  = id_uses_src1 & (id_src1 == ex_dest);
  assign src2_hit  = id_uses_src2 & (id_src2 == ex_dest);
  assign lu_hazard = ex_dmem_read & (ex_dest != 5'd0) & (src1_hit | src2_hit);

  assign if_instr     = rst ? 32'd0 : (hold_valid_q ? hold_instr_q : imem_rdata);
  assign imem_read    = ~rst & ~hold_valid_q;
  assign stall_cycles = stall_cnt_q;

  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (!rst && !freeze) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (ex_redirect) begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (lu_hazard) begin
        bubble_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    stall_cnt_d  = stall_cnt_q;
    if (freeze) begin
      // Keep an instruction that arrived while the data side was still waiting.
      if (!istall && dstall && imem_resp && !hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_instr_d = imem_rdata;
      end
    end else if (ex_redirect || !lu_hazard) begin
      hold_valid_d = 1'b0;
    end
    if (!load_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'd0;
      stall_cnt_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed vector table, corner sequences and randomized
// cycles checked against a rule-level model; a CNT_W=4 copy exercises counter saturation.
module tb_hazard_control_unit;

  typedef struct {
    bit          rst, iresp;
    logic [31:0] rd;
    bit          dreq, dresp, exrd;
    logic [4:0]  exd, s1;
    bit          u1;
    logic [4:0]  s2;
    bit          u2, redir;
  } in_t;

  typedef struct {
    in_t         x;
    logic [4:0]  loads;
    bit          fl, bu, ir;
    logic [31:0] ins;
    int          st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, imem_resp, dmem_req, dmem_resp;
  logic [31:0] imem_rdata;
  logic [4:0]  id_src1, id_src2, ex_dest;
  logic        id_uses_src1, id_uses_src2, ex_dmem_read, ex_redirect;

  logic        imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, bubble_id_ex;
  logic [31:0] if_instr, stall_cycles;
  logic        imem_read_s, load_pc_s, load_if_id_s, load_id_ex_s, load_ex_mem_s, load_mem_wb_s;
  logic        flush_if_id_s, bubble_id_ex_s;
  logic [31:0] if_instr_s;
  logic [3:0]  stall_cycles_s;

  int checks = 0;
  int errors = 0;

  bit          m_hv;
  logic [31:0] m_hi;
  longint      m_cnt;
  logic [4:0]  e_loads;
  bit          e_fl, e_bu, e_ir;
  logic [31:0] e_ins;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_dest(ex_dest),
    .ex_dmem_read(ex_dmem_read), .ex_redirect(ex_redirect), .imem_read(imem_read),
    .if_instr(if_instr), .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .stall_cycles(stall_cycles)
  );

  hazard_control_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2), .ex_dest(ex_dest),
    .ex_dmem_read(ex_dmem_read), .ex_redirect(ex_redirect), .imem_read(imem_read_s),
    .if_instr(if_instr_s), .load_pc(load_pc_s), .load_if_id(load_if_id_s),
    .load_id_ex(load_id_ex_s), .load_ex_mem(load_ex_mem_s), .load_mem_wb(load_mem_wb_s),
    .flush_if_id(flush_if_id_s), .bubble_id_ex(bubble_id_ex_s), .stall_cycles(stall_cycles_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t x;
    x = '{rst: 1'b0, iresp: 1'b1, rd: 32'h0, dreq: 1'b0, dresp: 1'b0, exrd: 1'b0,
          exd: 5'd0, s1: 5'd0, u1: 1'b0, s2: 5'd0, u2: 1'b0, redir: 1'b0};
    return x;
  endfunction

  function automatic vec_t v(input bit r, input bit ir_, input logic [31:0] rd, input bit dq,
                             input bit dr, input bit exrd, input logic [4:0] exd,
                             input logic [4:0] s1, input bit u1, input logic [4:0] s2,
                             input bit u2, input bit redir, input logic [4:0] loads,
                             input bit fl, input bit bu, input bit ir, input logic [31:0] ins,
                             input int st);
    vec_t t;
    t.x = '{rst: r, iresp: ir_, rd: rd, dreq: dq, dresp: dr, exrd: exrd, exd: exd,
            s1: s1, u1: u1, s2: s2, u2: u2, redir: redir};
    t.loads = loads; t.fl = fl; t.bu = bu; t.ir = ir; t.ins = ins; t.st = st;
    return t;
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst; imem_resp = x.iresp; imem_rdata = x.rd; dmem_req = x.dreq;
    dmem_resp = x.dresp; ex_dmem_read = x.exrd; ex_dest = x.exd; id_src1 = x.s1;
    id_uses_src1 = x.u1; id_src2 = x.s2; id_uses_src2 = x.u2; ex_redirect = x.redir;
  endtask

  // Expected combinational outputs derived from the priority rules rst > freeze > redirect > load-use.
  task automatic model_out(input in_t x);
    bit frozen, hazard;
    frozen = !(m_hv || x.iresp) || (x.dreq && !x.dresp);
    hazard = x.exrd && x.exd != 0 && ((x.u1 && x.s1 == x.exd) || (x.u2 && x.s2 == x.exd));
    e_fl = 0; e_bu = 0; e_loads = 5'b00000;
    if (x.rst || frozen) e_loads = 5'b00000;
    else if (x.redir) begin e_loads = 5'b11111; e_fl = 1; e_bu = 1; end
    else if (hazard) begin e_loads = 5'b00111; e_bu = 1; end
    else e_loads = 5'b11111;
    e_ir  = !x.rst && !m_hv;
    e_ins = x.rst ? 32'd0 : (m_hv ? m_hi : x.rd);
  endtask

  task automatic model_step(input in_t x);
    bit frozen, dwait;
    model_out(x);
    dwait  = x.dreq && !x.dresp;
    frozen = !(m_hv || x.iresp) || dwait;
    if (x.rst) begin
      m_hv = 0; m_hi = 0; m_cnt = 0;
    end else begin
      if (e_loads[4] == 1'b0) m_cnt++;
      if (frozen) begin
        if (!m_hv && x.iresp && dwait) begin m_hv = 1; m_hi = x.rd; end
      end else if (e_loads[4] || x.redir) begin
        m_hv = 0;
      end
    end
  endtask

  function automatic logic [4:0] dut_loads();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
  endfunction

  task automatic cycle(input in_t x, input bit check);
    longint sat;
    @(negedge clk);
    drive(x);
    #1;
    if (check) begin
      model_out(x);
      sat = (m_cnt > 15) ? 15 : m_cnt;
      chk("loads", 64'(dut_loads()), 64'(e_loads));
      chk("flush_if_id", 64'(flush_if_id), 64'(e_fl));
      chk("bubble_id_ex", 64'(bubble_id_ex), 64'(e_bu));
      chk("imem_read", 64'(imem_read), 64'(e_ir));
      chk("if_instr", 64'(if_instr), 64'(e_ins));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
      chk("stall_cycles_w4", 64'(stall_cycles_s), 64'(sat));
      chk("loads_w4", 64'({load_pc_s, load_if_id_s, load_id_ex_s, load_ex_mem_s, load_mem_wb_s}),
          64'(e_loads));
    end
    @(posedge clk);
    model_step(x);
  endtask

  vec_t tbl[27];

  initial begin
    in_t x;
    m_hv = 0; m_hi = 0; m_cnt = 0;
    tbl[0]  = v(1,1,32'hDEADBEEF,0,0,0,0,0,0,0,0,0, 5'b00000,0,0,0,32'h0,0);
    tbl[1]  = v(0,1,32'h11111111,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'h11111111,0);
    tbl[2]  = v(0,1,32'h22222222,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'h22222222,0);
    tbl[3]  = v(0,1,32'h33333333,0,0,1,5,5,1,0,0,0, 5'b00111,0,1,1,32'h33333333,0);
    tbl[4]  = v(0,1,32'h44444444,0,0,0,5,5,1,0,0,0, 5'b11111,0,0,1,32'h44444444,1);
    tbl[5]  = v(0,1,32'h55555555,0,0,1,0,0,1,0,0,0, 5'b11111,0,0,1,32'h55555555,1);
    tbl[6]  = v(0,1,32'h66666666,0,0,1,7,1,1,7,1,0, 5'b00111,0,1,1,32'h66666666,1);
    tbl[7]  = v(0,1,32'h77777777,0,0,1,7,0,0,7,0,0, 5'b11111,0,0,1,32'h77777777,2);
    tbl[8]  = v(0,1,32'h00A00093,1,0,0,0,0,0,0,0,0, 5'b00000,0,0,1,32'h00A00093,2);
    tbl[9]  = v(0,0,32'hBAD0BAD0,1,0,0,0,0,0,0,0,0, 5'b00000,0,0,0,32'h00A00093,3);
    tbl[10] = v(0,0,32'hBAD0BAD0,1,0,0,0,0,0,0,0,0, 5'b00000,0,0,0,32'h00A00093,4);
    tbl[11] = v(0,0,32'hBAD0BAD0,1,1,0,0,0,0,0,0,0, 5'b11111,0,0,0,32'h00A00093,5);
    tbl[12] = v(0,1,32'h44444444,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'h44444444,5);
    tbl[13] = v(0,0,32'h55555555,0,0,0,0,0,0,0,0,0, 5'b00000,0,0,1,32'h55555555,5);
    tbl[14] = v(0,1,32'h66666666,0,0,1,5,5,1,0,0,1, 5'b11111,1,1,1,32'h66666666,6);
    tbl[15] = v(0,1,32'h12121212,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'h12121212,6);
    tbl[16] = v(0,1,32'h77777777,1,0,0,0,0,0,0,0,0, 5'b00000,0,0,1,32'h77777777,6);
    tbl[17] = v(0,0,32'hBAD0BAD0,1,1,0,0,0,0,0,0,1, 5'b11111,1,1,0,32'h77777777,7);
    tbl[18] = v(0,0,32'h88888888,0,0,0,0,0,0,0,0,0, 5'b00000,0,0,1,32'h88888888,7);
    tbl[19] = v(0,1,32'h99999999,1,0,0,0,0,0,0,0,1, 5'b00000,0,0,1,32'h99999999,8);
    tbl[20] = v(0,0,32'hBAD0BAD0,1,0,0,0,0,0,0,0,1, 5'b00000,0,0,0,32'h99999999,9);
    tbl[21] = v(0,0,32'hBAD0BAD0,1,1,0,0,0,0,0,0,1, 5'b11111,1,1,0,32'h99999999,10);
    tbl[22] = v(0,1,32'hAAAAAAAA,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'hAAAAAAAA,10);
    tbl[23] = v(0,1,32'hBBBBBBBB,1,0,0,0,0,0,0,0,0, 5'b00000,0,0,1,32'hBBBBBBBB,10);
    tbl[24] = v(0,0,32'hBAD0BAD0,0,0,1,3,3,1,0,0,0, 5'b00111,0,1,0,32'hBBBBBBBB,11);
    tbl[25] = v(0,0,32'hBAD0BAD0,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,0,32'hBBBBBBBB,12);
    tbl[26] = v(0,1,32'hCCCCCCCC,0,0,0,0,0,0,0,0,0, 5'b11111,0,0,1,32'hCCCCCCCC,12);

    x = idle(); x.rst = 1;
    cycle(x, 0);
    cycle(x, 0);

    // Directed vector table
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(tbl[i].x);
      #1;
      $display("vec %0d: loads=%b flush=%b bubble=%b imem_read=%b if_instr=%h stall=%0d",
               i, dut_loads(), flush_if_id, bubble_id_ex, imem_read, if_instr, stall_cycles);
      chk($sformatf("vec%0d loads", i), 64'(dut_loads()), 64'(tbl[i].loads));
      chk($sformatf("vec%0d flush", i), 64'(flush_if_id), 64'(tbl[i].fl));
      chk($sformatf("vec%0d bubble", i), 64'(bubble_id_ex), 64'(tbl[i].bu));
      chk($sformatf("vec%0d imem_read", i), 64'(imem_read), 64'(tbl[i].ir));
      chk($sformatf("vec%0d if_instr", i), 64'(if_instr), 64'(tbl[i].ins));
      chk($sformatf("vec%0d stall", i), 64'(stall_cycles), 64'(tbl[i].st));
      chk($sformatf("vec%0d stall_w4", i), 64'(stall_cycles_s), 64'(tbl[i].st));
      @(posedge clk);
      model_step(tbl[i].x);
    end

    // Long instruction-side freeze: narrow counter saturates, wide one keeps counting
    x = idle(); x.rst = 1;
    cycle(x, 1);
    x = idle(); x.iresp = 0;
    for (int i = 0; i < 20; i++) cycle(x, 1);
    @(negedge clk);
    drive(x);
    #1;
    $display("saturation: stall=%0d stall_w4=%0d", stall_cycles, stall_cycles_s);
    chk("sat_w4", 64'(stall_cycles_s), 64'd15);
    chk("sat_w32", 64'(stall_cycles), 64'd20);
    @(posedge clk);
    model_step(x);

    // Reset in the middle of a data freeze with the buffer full
    x = idle(); x.dreq = 1; x.rd = 32'h0BADF00D;
    cycle(x, 1);
    x.iresp = 0;
    cycle(x, 1);
    x.rst = 1;
    cycle(x, 1);
    x = idle(); x.iresp = 0; x.rd = 32'h13579BDF;
    @(negedge clk);
    drive(x);
    #1;
    $display("post-reset: stall=%0d imem_read=%b if_instr=%h", stall_cycles, imem_read, if_instr);
    chk("rst_mid_freeze stall", 64'(stall_cycles), 64'd0);
    chk("rst_mid_freeze stall_w4", 64'(stall_cycles_s), 64'd0);
    chk("rst_mid_freeze imem_read", 64'(imem_read), 64'd1);
    chk("rst_mid_freeze if_instr", 64'(if_instr), 64'h13579BDF);
    @(posedge clk);
    model_step(x);

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      x.rst   = ($urandom_range(0, 31) == 0);
      x.iresp = ($urandom_range(0, 3) != 0);
      x.rd    = $urandom;
      x.dreq  = ($urandom_range(0, 2) == 0);
      x.dresp = $urandom_range(0, 1) == 1;
      x.exrd  = ($urandom_range(0, 2) == 0);
      x.exd   = 5'($urandom_range(0, 3));
      x.s1    = 5'($urandom_range(0, 3));
      x.s2    = 5'($urandom_range(0, 3));
      x.u1    = $urandom_range(0, 1) == 1;
      x.u2    = $urandom_range(0, 1) == 1;
      x.redir = ($urandom_range(0, 5) == 0);
      cycle(x, 1);
      $display("rand %0d: loads=%b flush=%b bubble=%b stall=%0d", i, dut_loads(),
               flush_if_id, bubble_id_ex, stall_cycles);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
